mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the instruction-fetch port and the data-memory port (loads/stores from the memory stage) of the rv32imc pipeline onto a single shared memory bus. Only one transaction is outstanding on the shared bus at a time. The arbiter holds the granted request stable until the bus responds, then returns the response to the owning requester. Round-robin grant prevents either stage from starving the other.

## Interface
- `DMEM_FIRST`, default 1: on a simultaneous request with no prior grant history (after reset), 1 grants dmem and 0 grants imem.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` in 1: fetch request, held level until `imem_resp`.
- `imem_addr` in 32: fetch address, stable while `imem_req`=1.
- `imem_rdata` out 32: fetch data, valid only when `imem_resp`=1.
- `imem_resp` out 1: one-cycle completion pulse.
- `dmem_rmask` in 4: byte read mask; nonzero means a read request.
- `dmem_wmask` in 4: byte write mask; nonzero means a write request.
- `dmem_addr` in 32: data address; stable while the request is held.
- `dmem_wdata` in 32: store data; stable while the request is held.
- `dmem_rdata` out 32: load data, valid only when `dmem_resp`=1.
- `dmem_resp` out 1: one-cycle completion pulse for both reads and writes.
- `bmem_addr` out 32: word-aligned bus address, `{addr[31:2],2'b00}`.
- `bmem_read` out 1: one-cycle read strobe.
- `bmem_write` out 1: one-cycle write strobe.
- `bmem_wmask` out 4: byte enables for writes; 0 for reads.
- `bmem_wdata` out 32: write data.
- `bmem_rdata` in 32: bus read data, valid with `bmem_resp`.
- `bmem_resp` in 1: bus completion pulse, one per strobe.

## Operation
- A dmem request is pending when `|dmem_rmask || |dmem_wmask`. If both masks are nonzero, the request is a write and `dmem_rmask` is ignored.
- FSM states:
  - IDLE: no transaction.
  - ISSUE: drives the strobe for one cycle.
  - WAIT: waits for `bmem_resp`.
  - Transitions: IDLE→ISSUE on grant; ISSUE→WAIT unconditionally; WAIT→IDLE on `bmem_resp`.
- `owner` register: selects imem or dmem, and is latched at grant.
- `last_grant` register: records the previous owner; reset value is "none".
- Grant rule in IDLE:
  - If only one request is pending, grant that requester.
  - If both are pending, grant the requester that is not `last_grant`.
  - If `last_grant` is "none", the `DMEM_FIRST` setting decides.
- At grant, the arbiter registers address, kind (read or write), wmask and wdata into the bus-side output registers. These are held constant through ISSUE and WAIT.
- `bmem_read`/`bmem_write` is asserted in ISSUE only.
- `bmem_addr`, `bmem_wmask` and `bmem_wdata` hold their value until the next grant. They read 0 after reset.
- In WAIT with `bmem_resp`=1, the arbiter drives the owner's `*_resp`=1 and `*_rdata`=`bmem_rdata` combinationally in the same cycle. The non-owner's resp stays 0.
- `imem_rdata` and `dmem_rdata` are 0 whenever their resp is 0.
- A requester deasserts its request in the cycle after its resp, or keeps it asserted to issue a new request. A request seen in IDLE is always treated as new.
- A `bmem_resp` arriving in IDLE or ISSUE is ignored: no upstream resp is produced and no state changes.
- Requests that change while not granted are simply re-sampled. The arbiter does not latch anything for the requester that lost arbitration.

## Timing
- Reset values: every output is 0; state=IDLE; `last_grant`=none.
- Reset asserted in ISSUE or WAIT abandons the transaction with no upstream resp. A `bmem_resp` arriving on or after the reset cycle for that abandoned transaction is ignored.
- Cycle-level sequence:
  - Request sampled in IDLE at cycle N.
  - Strobe at N+1.
  - Earliest `bmem_resp` at N+2.
  - Upstream resp in the same cycle as `bmem_resp`.
  - The next grant is evaluated at IDLE in the cycle after the resp.
- Minimum occupancy is 3 cycles per transaction. Back-to-back transactions issue a strobe at most every 4 cycles with a zero-wait bus.
- With both requesters continuously active, grants alternate strictly. Neither requester waits more than one foreign transaction.

## Test plan
- Single fetch:
  - Stimulus: `imem_req`=1, addr=0x0000_1006; `bmem_resp` 2 cycles after the strobe with rdata=0xDEADBEEF.
  - Required: `bmem_addr`=0x0000_1004 and `bmem_read` for exactly 1 cycle; `imem_resp`=1 with `imem_rdata`=0xDEADBEEF; `dmem_resp` stays 0.
- Store:
  - Stimulus: `dmem_wmask`=4'b0011, wdata=0x1234_5678, addr=0x80.
  - Required: `bmem_write`=1 for one cycle, `bmem_wmask`=0011, `bmem_wdata`=0x1234_5678; `dmem_resp` pulse when `bmem_resp` arrives.
- Contention:
  - Stimulus: after reset, both requests held for 4 transactions (`DMEM_FIRST`=1).
  - Required: grant order dmem, imem, dmem, imem; each resp goes only to its owner.
- Mask conflict:
  - Stimulus: `dmem_rmask`=1111 and `dmem_wmask`=0001.
  - Required: bus sees a write with wmask 0001; no read strobe.
- Spurious bus response:
  - Stimulus: `bmem_resp` pulsed while IDLE.
  - Required: no `imem_resp`/`dmem_resp`; the following request completes normally.
- Reset mid-transaction:
  - Stimulus: `rst` in WAIT; `bmem_resp` arrives on the cycle after reset.
  - Required: all outputs 0, no upstream resp; a subsequent `imem_req` is granted with the `DMEM_FIRST` tie-break restored.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter placing the instruction-fetch and data-memory
//            ports onto one shared memory bus, one transaction at a time.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter logic DMEM_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    // instruction-fetch port
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    // data-memory port
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    // shared bus
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    output logic        bmem_write,
    output logic [3:0]  bmem_wmask,
    output logic [31:0] bmem_wdata,
    input  logic [31:0] bmem_rdata,
    input  logic        bmem_resp
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LG_NONE = 2'd0,
        LG_IMEM = 2'd1,
        LG_DMEM = 2'd2
    } last_t;

    state_t      r_state;
    last_t       r_last_grant;
    logic        r_owner_dmem;
    logic [31:0] r_bmem_addr;
    logic        r_bmem_read;
    logic        r_bmem_write;
    logic [3:0]  r_bmem_wmask;
    logic [31:0] r_bmem_wdata;

    logic        w_dmem_pend;
    logic        w_dmem_write;
    logic        w_grant_dmem;
    logic        w_done;

    // Byte offsets are dropped because the bus is word addressed.
    logic        w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = &{1'b0, imem_addr[1:0], dmem_addr[1:0]};

    // A nonzero write mask wins over any read mask.
    assign w_dmem_pend  = (|dmem_rmask) | (|dmem_wmask);
    assign w_dmem_write = |dmem_wmask;

    // Round-robin choice: lone requester wins, a tie goes to whoever did not go last.
    always_comb begin
        w_grant_dmem = 1'b0;
        if (w_dmem_pend && !imem_req) begin
            w_grant_dmem = 1'b1;
        end else if (w_dmem_pend && imem_req) begin
            case (r_last_grant)
                LG_IMEM: w_grant_dmem = 1'b1;
                LG_DMEM: w_grant_dmem = 1'b0;
                default: w_grant_dmem = DMEM_FIRST;
            endcase
        end
    end

    // Bus completion only counts in WAIT; a response during reset belongs to an abandoned transaction.
    assign w_done     = (r_state == S_WAIT) && bmem_resp && !rst;
    assign imem_resp  = w_done && !r_owner_dmem;
    assign dmem_resp  = w_done && r_owner_dmem;
    assign imem_rdata = imem_resp ? bmem_rdata : 32'd0;
    assign dmem_rdata = dmem_resp ? bmem_rdata : 32'd0;

    assign bmem_addr  = r_bmem_addr;
    assign bmem_read  = r_bmem_read;
    assign bmem_write = r_bmem_write;
    assign bmem_wmask = r_bmem_wmask;
    assign bmem_wdata = r_bmem_wdata;

    // Arbitration FSM: grant in IDLE, strobe for one cycle in ISSUE, hold until bus response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= LG_NONE;
            r_owner_dmem <= 1'b0;
            r_bmem_addr  <= 32'd0;
            r_bmem_read  <= 1'b0;
            r_bmem_write <= 1'b0;
            r_bmem_wmask <= 4'd0;
            r_bmem_wdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (imem_req || w_dmem_pend) begin
                        r_state      <= S_ISSUE;
                        r_owner_dmem <= w_grant_dmem;
                        if (w_grant_dmem) begin
                            r_last_grant <= LG_DMEM;
                            r_bmem_addr  <= {dmem_addr[31:2], 2'b00};
                            r_bmem_read  <= !w_dmem_write;
                            r_bmem_write <= w_dmem_write;
                            r_bmem_wmask <= w_dmem_write ? dmem_wmask : 4'd0;
                            r_bmem_wdata <= dmem_wdata;
                        end else begin
                            r_last_grant <= LG_IMEM;
                            r_bmem_addr  <= {imem_addr[31:2], 2'b00};
                            r_bmem_read  <= 1'b1;
                            r_bmem_write <= 1'b0;
                            r_bmem_wmask <= 4'd0;
                            r_bmem_wdata <= 32'd0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_bmem_read  <= 1'b0;
                    r_bmem_write <= 1'b0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (bmem_resp) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with a transaction-level
//            reference model of the grant and bus-mapping rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int G_NONE = 0;
    localparam int G_IMEM = 1;
    localparam int G_DMEM = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [3:0]  bmem_wmask;
    logic [31:0] bmem_wdata;
    logic [31:0] bmem_rdata;
    logic        bmem_resp;

    int checks = 0;
    int errors = 0;
    int lg     = G_NONE;   // model: previous owner
    int order [4];

    mem_arbiter #(.DMEM_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wmask (bmem_wmask),
        .bmem_wdata (bmem_wdata),
        .bmem_rdata (bmem_rdata),
        .bmem_resp  (bmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_imem_resp"},  32'(imem_resp),  32'd0);
        chk({tag, "_imem_rdata"}, imem_rdata,      32'd0);
        chk({tag, "_dmem_resp"},  32'(dmem_resp),  32'd0);
        chk({tag, "_dmem_rdata"}, dmem_rdata,      32'd0);
        chk({tag, "_bmem_addr"},  bmem_addr,       32'd0);
        chk({tag, "_strobes"},    32'({bmem_read, bmem_write}), 32'd0);
        chk({tag, "_bmem_wmask"}, 32'(bmem_wmask), 32'd0);
        chk({tag, "_bmem_wdata"}, bmem_wdata,      32'd0);
    endtask

    // Reference grant rule, evaluated on the currently driven requests.
    function automatic int model_owner();
        bit ip, dp;
        ip = imem_req;
        dp = (dmem_rmask != 4'd0) || (dmem_wmask != 4'd0);
        if (ip && !dp) return G_IMEM;
        if (dp && !ip) return G_DMEM;
        if (!ip && !dp) return G_NONE;
        if (lg == G_NONE) return G_DMEM;   // DMEM_FIRST = 1
        return (lg == G_IMEM) ? G_DMEM : G_IMEM;
    endfunction

    task automatic new_dmem();
        dmem_wmask = 4'($urandom_range(0, 15));
        dmem_rmask = (dmem_wmask == 4'd0) ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
        dmem_addr  = $urandom;
        dmem_wdata = $urandom;
    endtask

    // Runs one bus transaction from an IDLE DUT whose requests were just applied.
    // k = extra WAIT cycles before bmem_resp; renew = owner issues a fresh request afterwards.
    task automatic serve(input int k, input logic [31:0] rd, input bit renew, output int obs_own);
        int          own;
        int          waited;
        bit          seen;
        bit          wr;
        logic [31:0] ea;
        logic [3:0]  ewm;
        logic [31:0] ewd;
        obs_own = G_NONE;
        own = model_owner();
        if (own == G_DMEM) begin
            wr  = (dmem_wmask != 4'd0);
            ea  = {dmem_addr[31:2], 2'b00};
            ewm = wr ? dmem_wmask : 4'd0;
            ewd = dmem_wdata;
        end else begin
            wr  = 1'b0;
            ea  = {imem_addr[31:2], 2'b00};
            ewm = 4'd0;
            ewd = 32'd0;
        end
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 4) begin
            @(negedge clk); #1;
            waited++;
            seen = bmem_read | bmem_write;
        end
        chk("strobe_latency", 32'(waited), 32'd1);
        if (!seen) return;
        chk("strobe_kind", 32'({bmem_write, bmem_read}), wr ? 32'd2 : 32'd1);
        chk("bmem_addr", bmem_addr, ea);
        chk("bmem_wmask", 32'(bmem_wmask), 32'(ewm));
        if (wr) chk("bmem_wdata", bmem_wdata, ewd);
        chk("issue_no_resp", 32'({imem_resp, dmem_resp}), 32'd0);
        lg = own;
        for (int i = 0; i < k; i++) begin
            @(negedge clk); #1;
            chk("strobe_one_cycle", 32'({bmem_read, bmem_write}), 32'd0);
            chk("wait_no_resp", 32'({imem_resp, dmem_resp}), 32'd0);
        end
        @(negedge clk);
        bmem_resp  = 1'b1;
        bmem_rdata = rd;
        #1;
        chk("strobe_one_cycle", 32'({bmem_read, bmem_write}), 32'd0);
        chk("bmem_addr_held", bmem_addr, ea);
        chk("bmem_wmask_held", 32'(bmem_wmask), 32'(ewm));
        chk("imem_resp", 32'(imem_resp), 32'(own == G_IMEM));
        chk("dmem_resp", 32'(dmem_resp), 32'(own == G_DMEM));
        chk("imem_rdata", imem_rdata, (own == G_IMEM) ? rd : 32'd0);
        chk("dmem_rdata", dmem_rdata, (own == G_DMEM) ? rd : 32'd0);
        obs_own = imem_resp ? G_IMEM : (dmem_resp ? G_DMEM : G_NONE);
        @(negedge clk);
        bmem_resp  = 1'b0;
        bmem_rdata = $urandom;
        if (own == G_IMEM) begin
            imem_req  = renew;
            imem_addr = $urandom;
        end else if (renew) begin
            new_dmem();
        end else begin
            dmem_rmask = 4'd0;
            dmem_wmask = 4'd0;
        end
        #1;
        chk("resp_single_pulse", 32'({imem_resp, dmem_resp}), 32'd0);
    endtask

    initial begin
        int o;
        rst        = 1'b1;
        imem_req   = 1'b0;
        imem_addr  = 32'd0;
        dmem_rmask = 4'd0;
        dmem_wmask = 4'd0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        bmem_rdata = 32'd0;
        bmem_resp  = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        lg  = G_NONE;

        // single fetch, response two cycles after the strobe
        imem_req  = 1'b1;
        imem_addr = 32'h0000_1006;
        serve(1, 32'hDEAD_BEEF, 1'b0, o);
        chk("fetch_owner", 32'(o), 32'(G_IMEM));
        chk("fetch_addr_hold", bmem_addr, 32'h0000_1004);

        // store
        dmem_wmask = 4'b0011;
        dmem_wdata = 32'h1234_5678;
        dmem_addr  = 32'h0000_0080;
        serve(0, $urandom, 1'b0, o);
        chk("store_owner", 32'(o), 32'(G_DMEM));
        chk("store_wdata_hold", bmem_wdata, 32'h1234_5678);

        // mask conflict: write wins
        dmem_rmask = 4'b1111;
        dmem_wmask = 4'b0001;
        dmem_addr  = 32'h0000_0103;
        dmem_wdata = 32'hA5A5_5A5A;
        serve(2, $urandom, 1'b0, o);
        chk("conflict_wmask_hold", 32'(bmem_wmask), 32'h1);

        // spurious bus response in IDLE
        @(negedge clk);
        bmem_resp = 1'b1;
        #1 chk("spurious_no_resp", 32'({imem_resp, dmem_resp}), 32'd0);
        @(negedge clk);
        bmem_resp = 1'b0;
        #1 chk("spurious_no_strobe", 32'({bmem_read, bmem_write}), 32'd0);
        imem_req  = 1'b1;
        imem_addr = 32'h0000_2000;
        serve(0, 32'hCAFE_F00D, 1'b0, o);
        chk("after_spurious_owner", 32'(o), 32'(G_IMEM));

        // contention after reset: strict alternation starting with dmem
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lg  = G_NONE;
        imem_req   = 1'b1;
        imem_addr  = 32'h0000_3000;
        dmem_rmask = 4'b1111;
        dmem_wmask = 4'b0000;
        dmem_addr  = 32'h0000_4000;
        for (int t = 0; t < 4; t++) begin
            serve(int'($urandom_range(0, 2)), $urandom, (t < 3), o);
            order[t] = o;
        end
        imem_req   = 1'b0;
        dmem_rmask = 4'd0;
        dmem_wmask = 4'd0;
        chk("contention_0", 32'(order[0]), 32'(G_DMEM));
        chk("contention_1", 32'(order[1]), 32'(G_IMEM));
        chk("contention_2", 32'(order[2]), 32'(G_DMEM));
        chk("contention_3", 32'(order[3]), 32'(G_IMEM));

        // reset while waiting for the bus
        @(negedge clk);
        imem_req  = 1'b1;
        imem_addr = 32'h0000_5008;
        @(negedge clk); #1;
        chk("midrst_strobe", 32'(bmem_read), 32'd1);
        @(negedge clk);
        rst      = 1'b1;
        imem_req = 1'b0;
        #1 chk("midrst_no_resp", 32'({imem_resp, dmem_resp}), 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        bmem_resp  = 1'b1;
        bmem_rdata = 32'h1111_2222;
        lg         = G_NONE;
        #1 chk_all_zero("after_rst");
        @(negedge clk);
        bmem_resp  = 1'b0;
        imem_req   = 1'b1;
        imem_addr  = 32'h0000_6000;
        dmem_rmask = 4'b0001;
        dmem_addr  = 32'h0000_7004;
        serve(0, $urandom, 1'b0, o);
        chk("tiebreak_restored", 32'(o), 32'(G_DMEM));
        serve(0, $urandom, 1'b0, o);
        chk("tiebreak_second", 32'(o), 32'(G_IMEM));

        // randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            if (!imem_req && dmem_rmask == 4'd0 && dmem_wmask == 4'd0) begin
                case ($urandom_range(1, 3))
                    1: begin imem_req = 1'b1; imem_addr = $urandom; end
                    2: new_dmem();
                    default: begin imem_req = 1'b1; imem_addr = $urandom; new_dmem(); end
                endcase
            end
            serve(int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), o);
        end
        imem_req   = 1'b0;
        dmem_rmask = 4'd0;
        dmem_wmask = 4'd0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
